execute: RTL and testbench
==========================

# execute

Execute stage of the Y86-64 five-stage pipeline, between the E pipeline register (decode side) and the memory stage. It computes the ALU result and the evaluated condition, holds the ZF/SF/OF condition-code register, and registers everything the memory stage consumes into the M pipeline register. It also drives the unregistered `e_*` values used for forwarding and branch-misprediction control.

## Interface
No parameters; the data width is fixed at 64 bits.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `E_stat` in [0:3]: status of the instruction in E.
- `E_icode`, `E_ifun` in 4 each: instruction code and function code.
- `E_valC`, `E_valA`, `E_valB`, `E_valP` in 64 each: constant, operand A, operand B, next PC.
- `E_dstE`, `E_dstM` in 4 each: destination register IDs.
- `m_stat`, `W_stat` in [0:3]: statuses from the memory and writeback stages, used to gate the CC update.
- `M_bubble` in 1: from pipeline control; inserts a bubble into M.
- `e_valE` out 64: combinational ALU result.
- `e_Cnd` out 1: combinational condition result.
- `e_dstE` out 4: combinational effective dstE, used for forwarding.
- `cc` out 3: current {ZF,SF,OF}, registered.
- `M_stat` out [0:3], `M_icode` out 4, `M_cnd` out 1.
- `M_valE`, `M_valA`, `M_valP` out 64 each.
- `M_dstE`, `M_dstM` out 4 each.

## Operation
- Status codes: AOK=4'b1000, HLT=4'b0100, ADR=4'b0010, INS=4'b0001. RNONE=4'hF.
- Icodes: 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
- ALU input `aluA` by icode:
  - E_valA for 2 and 6.
  - E_valC for 3, 4 and 5.
  - -8 for 8 and A.
  - +8 for 9 and B.
  - 0 for all other icodes.
- ALU input `aluB`: E_valB for 4, 5, 6, 8, 9, A and B; 0 otherwise.
- ALU function: E_ifun when icode=6 (0 add, 1 sub, 2 and, 3 xor); add for every other icode. For OPq with ifun>3 the result is 0 and the flags are ZF=1, SF=0, OF=0.
- Result: sub computes aluB−aluA. All arithmetic is 64-bit two's complement and wraps silently.
- Flags:
  - ZF = result==0.
  - SF = result[63].
  - OF for add: (aluA[63]==aluB[63]) && (result[63]!=aluA[63]).
  - OF for sub: (aluA[63]!=aluB[63]) && (result[63]!=aluB[63]).
  - OF for and/xor: 0.
- CC update (`set_cc`): only when E_icode=6 && E_stat=AOK && m_stat=AOK && W_stat=AOK. Otherwise `cc` holds its value.
- Condition `e_Cnd`, evaluated from the current registered `cc`, by E_ifun:
  - 0: always 1.
  - 1 (le): (SF^OF)|ZF.
  - 2 (l): SF^OF.
  - 3 (e): ZF.
  - 4 (ne): !ZF.
  - 5 (ge): !(SF^OF).
  - 6 (g): !(SF^OF)&!ZF.
  - 7–F: 0.
  - Evaluated for every icode; meaningful only for 2 and 7.
- `e_dstE` = RNONE when E_icode=2 && !e_Cnd; otherwise E_dstE.
- M register loads on every rising edge; the stage never stalls. Normal load values:
  - M_stat←E_stat, M_icode←E_icode, M_cnd←e_Cnd.
  - M_valE←e_valE, M_valA←E_valA, M_valP←E_valP.
  - M_dstE←e_dstE, M_dstM←E_dstM.
- Bubble value, loaded when M_bubble=1:
  - M_stat=AOK, M_icode=1, M_cnd=0.
  - M_valE=M_valA=M_valP=0.
  - M_dstE=M_dstM=RNONE.

## Timing
- Reset (rst_n=0 at a rising edge): M register takes the bubble value; cc={ZF=1,SF=0,OF=0}. Reset has priority over M_bubble.
- `e_valE`, `e_Cnd` and `e_dstE` are combinational from the E inputs and `cc`, valid in the same cycle.
- `cc` updates at the rising edge that ends the OPq's E cycle. An instruction in E during that same cycle sees the old `cc`; the next instruction sees the new value.
- Latency: E inputs to M outputs, exactly 1 cycle.
- Interaction with the memory stage: an instruction whose m_stat is non-AOK blocks the CC update of the instruction behind it in that same cycle. The blocked CC change is never applied later.
- M_bubble and set_cc in the same cycle: the CC update still happens if its gates pass. The bubble affects only the M register.
- rst_n low for several cycles: outputs hold their reset values. Normal operation starts at the first edge with rst_n=1.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants;
  - status constants;
  - RNONE;
  - ALU function codes;
  - condition-function codes;
  - the M bubble value.
- Sub-module `alu64`: purely combinational; inputs aluA, aluB, alufun; outputs result and {ZF,SF,OF}.
- The CC register, condition logic and M register are implemented in `execute`.

## Test plan
- **OPq add overflow:** reset, then icode=6 ifun=0 valA=64'h7FFF_FFFF_FFFF_FFFF valB=1. Required: e_valE=64'h8000_0000_0000_0000; after the edge cc={0,1,1}.
- **Sub then jXX:** OPq sub valA=5 valB=5, then jXX ifun=3. Required: e_Cnd=1 and M_cnd=1 for the jXX. Repeat with valB=6: e_Cnd=0.
- **cmov not taken:** cc={0,0,0}, icode=2 ifun=3 dstE=3. Required: e_dstE=4'hF, M_dstE=4'hF, e_valE=valA.
- **Stack ops:** call valB=64'h100 gives e_valE=64'hF8; ret valB=64'h100 gives e_valE=64'h108; M_valP passes through unchanged.
- **CC gating:** OPq xor valA=valB=7 with m_stat=ADR. Required: cc unchanged; M_stat=E_stat.
- **Bubble and reset:** M_bubble=1 gives M_icode=1, M_dstE=M_dstM=4'hF, M_stat=AOK. rst_n=0 while M_bubble=0 gives the same values and cc={1,0,0}.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction/status codes, ALU and condition
// function codes, and the M pipeline register layout with its bubble value.
`default_nettype none

package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [0:3] STAT_AOK = 4'b1000;
  localparam logic [0:3] STAT_HLT = 4'b0100;
  localparam logic [0:3] STAT_ADR = 4'b0010;
  localparam logic [0:3] STAT_INS = 4'b0001;

  localparam logic [3:0] RNONE = 4'hF;

  // ALU_NONE covers OPq function codes above 3: zero result, ZF only.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_XOR  = 3'd3,
    ALU_NONE = 3'd4
  } alufun_e;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  typedef struct packed {
    logic [0:3]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } m_reg_t;

  localparam m_reg_t M_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    cnd:   1'b0,
    valE:  64'd0,
    valA:  64'd0,
    valP:  64'd0,
    dstE:  RNONE,
    dstM:  RNONE
  };

endpackage

`default_nettype wire

// File: rtl/alu64.sv
// Combinational 64-bit Y86 ALU producing the result and {ZF,SF,OF}.
`default_nettype none

module alu64
  import y86_pkg::*;
(
  input  logic [63:0] aluA,
  input  logic [63:0] aluB,
  input  alufun_e     alufun,
  output logic [63:0] result,
  output logic [2:0]  flags
);

  logic of;

  always_comb begin
    result = 64'd0;
    of     = 1'b0;
    case (alufun)
      ALU_ADD: begin
        result = aluB + aluA;
        of     = (aluA[63] == aluB[63]) && (result[63] != aluA[63]);
      end
      ALU_SUB: begin
        result = aluB - aluA;
        of     = (aluA[63] != aluB[63]) && (result[63] != aluB[63]);
      end
      ALU_AND: result = aluB & aluA;
      ALU_XOR: result = aluB ^ aluA;
      default: result = 64'd0;
    endcase
  end

  assign flags = {(result == 64'd0), result[63], of};

endmodule

`default_nettype wire

// File: rtl/execute.sv
// Y86-64 execute stage: ALU operand selection, CC register, condition
// evaluation and the M pipeline register.
`default_nettype none

module execute
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:3]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valC,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [63:0] E_valP,
  input  logic [3:0]  E_dstE,
  input  logic [3:0]  E_dstM,
  input  logic [0:3]  m_stat,
  input  logic [0:3]  W_stat,
  input  logic        M_bubble,
  output logic [63:0] e_valE,
  output logic        e_Cnd,
  output logic [3:0]  e_dstE,
  output logic [2:0]  cc,
  output logic [0:3]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [63:0] M_valP,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM
);

  logic [63:0] alu_a, alu_b;
  alufun_e     alufun;
  logic [2:0]  alu_flags;
  logic [2:0]  cc_q, cc_d;
  logic        set_cc;
  logic        zf, sf, of;
  m_reg_t      m_q, m_d;

  always_comb begin
    alu_a = 64'd0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:            alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:            alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:              alu_a = 64'd8;
      default:                    alu_a = 64'd0;
    endcase
  end

  always_comb begin
    alu_b = 64'd0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
      default: alu_b = 64'd0;
    endcase
  end

  always_comb begin
    alufun = ALU_ADD;
    if (E_icode == I_OPQ) begin
      case (E_ifun)
        4'h0:    alufun = ALU_ADD;
        4'h1:    alufun = ALU_SUB;
        4'h2:    alufun = ALU_AND;
        4'h3:    alufun = ALU_XOR;
        default: alufun = ALU_NONE;
      endcase
    end
  end

  alu64 u_alu (
    .aluA   (alu_a),
    .aluB   (alu_b),
    .alufun (alufun),
    .result (e_valE),
    .flags  (alu_flags)
  );

  // A faulting instruction ahead in M or W suppresses the update permanently.
  assign set_cc = (E_icode == I_OPQ) && (E_stat == STAT_AOK) &&
                  (m_stat == STAT_AOK) && (W_stat == STAT_AOK);
  assign cc_d   = set_cc ? alu_flags : cc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) cc_q <= 3'b100;
    else        cc_q <= cc_d;
  end

  assign {zf, sf, of} = cc_q;
  assign cc = cc_q;

  always_comb begin
    e_Cnd = 1'b0;
    case (E_ifun)
      C_YES:   e_Cnd = 1'b1;
      C_LE:    e_Cnd = (sf ^ of) | zf;
      C_L:     e_Cnd = sf ^ of;
      C_E:     e_Cnd = zf;
      C_NE:    e_Cnd = ~zf;
      C_GE:    e_Cnd = ~(sf ^ of);
      C_G:     e_Cnd = ~(sf ^ of) & ~zf;
      default: e_Cnd = 1'b0;
    endcase
  end

  assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;

  always_comb begin
    m_d       = M_BUBBLE;
    m_d.stat  = E_stat;
    m_d.icode = E_icode;
    m_d.cnd   = e_Cnd;
    m_d.valE  = e_valE;
    m_d.valA  = E_valA;
    m_d.valP  = E_valP;
    m_d.dstE  = e_dstE;
    m_d.dstM  = E_dstM;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        m_q <= M_BUBBLE;
    else if (M_bubble) m_q <= M_BUBBLE;
    else               m_q <= m_d;
  end

  assign M_stat  = m_q.stat;
  assign M_icode = m_q.icode;
  assign M_cnd   = m_q.cnd;
  assign M_valE  = m_q.valE;
  assign M_valA  = m_q.valA;
  assign M_valP  = m_q.valP;
  assign M_dstE  = m_q.dstE;
  assign M_dstM  = m_q.dstM;

endmodule

`default_nettype wire

// File: tb/tb_execute.sv
// Directed self-checking bench for the execute stage.
`default_nettype none

module tb_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:3]  E_stat, m_stat, W_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valC, E_valA, E_valB, E_valP;
  logic        M_bubble;
  logic [63:0] e_valE;
  logic        e_Cnd;
  logic [3:0]  e_dstE;
  logic [2:0]  cc;
  logic [0:3]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE, M_valA, M_valP;
  logic [3:0]  M_dstE, M_dstM;

  int checks = 0;
  int errors = 0;

  execute dut (
    .clk(clk), .rst_n(rst_n),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_valP(E_valP),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_Cnd(e_Cnd), .e_dstE(e_dstE), .cc(cc),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_valP(M_valP),
    .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] valA, input logic [63:0] valB,
                       input logic [63:0] valC, input logic [63:0] valP,
                       input logic [3:0] dstE, input logic [3:0] dstM);
    E_stat = 4'b1000; m_stat = 4'b1000; W_stat = 4'b1000;
    E_icode = icode; E_ifun = ifun;
    E_valA = valA; E_valB = valB; E_valC = valC; E_valP = valP;
    E_dstE = dstE; E_dstM = dstM;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; M_bubble = 1'b0;
    set_e(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'h40, 4'h2, 4'h3);
    repeat (2) tick();
    checks++; if (M_icode !== 4'h1) begin errors++; $display("FAIL reset_icode: got %h want 1", M_icode); end
    checks++; if (M_stat !== 4'b1000) begin errors++; $display("FAIL reset_stat: got %b want 1000", M_stat); end
    checks++; if ({M_dstE, M_dstM} !== 8'hFF) begin errors++; $display("FAIL reset_dst: got %h want ff", {M_dstE, M_dstM}); end
    checks++; if ({M_valE, M_valA, M_valP, M_cnd} !== 193'd0) begin errors++; $display("FAIL reset_vals: got nonzero M values/cnd"); end
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL reset_cc: got %b want 100", cc); end
    rst_n = 1'b1;
  endtask

  task automatic test_add_overflow();
    set_e(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'h40, 4'h2, 4'hF);
    checks++; if (e_valE !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL add_ovf_valE: got %h want 8000000000000000", e_valE); end
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL add_ovf_cc_before: got %b want 100", cc); end
    tick();
    checks++; if (cc !== 3'b011) begin errors++; $display("FAIL add_ovf_cc: got %b want 011", cc); end
    checks++; if (M_valE !== 64'h8000_0000_0000_0000 || M_dstE !== 4'h2) begin errors++; $display("FAIL add_ovf_M: got valE %h dstE %h", M_valE, M_dstE); end
    // cc = {0,1,1}: SF^OF = 0
    set_e(4'h7, 4'h2, 64'd0, 64'd0, 64'h80, 64'h49, 4'hF, 4'hF);
    checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL cond_l: got %b want 0", e_Cnd); end
    set_e(4'h7, 4'h6, 64'd0, 64'd0, 64'h80, 64'h49, 4'hF, 4'hF);
    checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL cond_g: got %b want 1", e_Cnd); end
    set_e(4'h7, 4'h9, 64'd0, 64'd0, 64'h80, 64'h49, 4'hF, 4'hF);
    checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL cond_bad_ifun: got %b want 0", e_Cnd); end
  endtask

  task automatic test_sub_jxx();
    set_e(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 64'h10, 4'h1, 4'hF);
    checks++; if (e_valE !== 64'd0) begin errors++; $display("FAIL sub_eq_valE: got %h want 0", e_valE); end
    tick();
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL sub_eq_cc: got %b want 100", cc); end
    set_e(4'h7, 4'h3, 64'd0, 64'd0, 64'h200, 64'h19, 4'hF, 4'hF);
    checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL je_taken: got %b want 1", e_Cnd); end
    tick();
    checks++; if (M_cnd !== 1'b1 || M_icode !== 4'h7) begin errors++; $display("FAIL je_M: got cnd %b icode %h want 1 7", M_cnd, M_icode); end
    set_e(4'h6, 4'h1, 64'd5, 64'd6, 64'd0, 64'h22, 4'h1, 4'hF);
    tick();
    checks++; if (cc !== 3'b000) begin errors++; $display("FAIL sub_ne_cc: got %b want 000", cc); end
    set_e(4'h7, 4'h3, 64'd0, 64'd0, 64'h200, 64'h2B, 4'hF, 4'hF);
    checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL je_not_taken: got %b want 0", e_Cnd); end
    tick();
    checks++; if (M_cnd !== 1'b0) begin errors++; $display("FAIL je_not_taken_M: got %b want 0", M_cnd); end
  endtask

  task automatic test_cmov();
    set_e(4'h2, 4'h3, 64'h1234, 64'h99, 64'd0, 64'h30, 4'h3, 4'hF);
    checks++; if (e_dstE !== 4'hF) begin errors++; $display("FAIL cmov_e_dstE: got %h want f", e_dstE); end
    checks++; if (e_valE !== 64'h1234) begin errors++; $display("FAIL cmov_valE: got %h want 1234", e_valE); end
    tick();
    checks++; if (M_dstE !== 4'hF) begin errors++; $display("FAIL cmov_M_dstE: got %h want f", M_dstE); end
    set_e(4'h2, 4'h0, 64'h55, 64'h99, 64'd0, 64'h32, 4'h3, 4'hF);
    checks++; if (e_dstE !== 4'h3) begin errors++; $display("FAIL rrmov_dstE: got %h want 3", e_dstE); end
  endtask

  task automatic test_stack();
    set_e(4'h8, 4'h0, 64'd0, 64'h100, 64'h500, 64'h77, 4'h4, 4'hF);
    checks++; if (e_valE !== 64'hF8) begin errors++; $display("FAIL call_valE: got %h want f8", e_valE); end
    tick();
    checks++; if (M_valP !== 64'h77 || M_valE !== 64'hF8) begin errors++; $display("FAIL call_M: got valP %h valE %h want 77 f8", M_valP, M_valE); end
    set_e(4'h9, 4'h0, 64'h100, 64'h100, 64'd0, 64'h88, 4'h4, 4'hF);
    checks++; if (e_valE !== 64'h108) begin errors++; $display("FAIL ret_valE: got %h want 108", e_valE); end
    tick();
    checks++; if (M_valP !== 64'h88 || M_valA !== 64'h100) begin errors++; $display("FAIL ret_M: got valP %h valA %h want 88 100", M_valP, M_valA); end
    set_e(4'h5, 4'h0, 64'h0, 64'h1000, 64'h18, 64'h90, 4'hF, 4'h6);
    checks++; if (e_valE !== 64'h1018) begin errors++; $display("FAIL mrmov_valE: got %h want 1018", e_valE); end
  endtask

  task automatic test_cc_gating();
    set_e(4'h6, 4'h3, 64'd7, 64'd7, 64'd0, 64'hA0, 4'h5, 4'hF);
    m_stat = 4'b0010; #1;
    tick();
    checks++; if (cc !== 3'b000) begin errors++; $display("FAIL gate_m_cc: got %b want 000", cc); end
    checks++; if (M_stat !== 4'b1000 || M_valE !== 64'd0) begin errors++; $display("FAIL gate_m_M: got stat %b valE %h", M_stat, M_valE); end
    set_e(4'h6, 4'h3, 64'd7, 64'd7, 64'd0, 64'hA2, 4'h5, 4'hF);
    W_stat = 4'b0100; #1;
    tick();
    checks++; if (cc !== 3'b000) begin errors++; $display("FAIL gate_w_cc: got %b want 000", cc); end
    set_e(4'h6, 4'h3, 64'd7, 64'd7, 64'd0, 64'hA4, 4'h5, 4'hF);
    E_stat = 4'b0001; #1;
    tick();
    checks++; if (cc !== 3'b000 || M_stat !== 4'b0001) begin errors++; $display("FAIL gate_e: got cc %b stat %b want 000 0001", cc, M_stat); end
    set_e(4'h6, 4'h7, 64'd3, 64'd4, 64'd0, 64'hA6, 4'h5, 4'hF);
    checks++; if (e_valE !== 64'd0) begin errors++; $display("FAIL bad_opq_valE: got %h want 0", e_valE); end
    tick();
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL bad_opq_cc: got %b want 100", cc); end
  endtask

  task automatic test_bubble_and_reset();
    set_e(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'hB0, 4'h2, 4'h3);
    M_bubble = 1'b1;
    tick();
    M_bubble = 1'b0;
    checks++; if (M_icode !== 4'h1 || M_stat !== 4'b1000) begin errors++; $display("FAIL bubble_icode_stat: got %h %b want 1 1000", M_icode, M_stat); end
    checks++; if ({M_dstE, M_dstM} !== 8'hFF || M_valE !== 64'd0 || M_cnd !== 1'b0) begin errors++; $display("FAIL bubble_vals: got dst %h valE %h cnd %b", {M_dstE, M_dstM}, M_valE, M_cnd); end
    checks++; if (cc !== 3'b011) begin errors++; $display("FAIL bubble_cc: got %b want 011", cc); end
    rst_n = 1'b0;
    set_e(4'h6, 4'h1, 64'd1, 64'd9, 64'd0, 64'hC0, 4'h2, 4'h3);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (M_icode !== 4'h1 || {M_dstE, M_dstM} !== 8'hFF || M_stat !== 4'b1000 || cc !== 3'b100)
        begin errors++; $display("FAIL reset_hold_%0d: got icode %h dst %h stat %b cc %b", i, M_icode, {M_dstE, M_dstM}, M_stat, cc); end
    end
    rst_n = 1'b1;
    tick();
    checks++; if (M_icode !== 4'h6 || M_valE !== 64'd8 || cc !== 3'b000) begin errors++; $display("FAIL post_reset: got icode %h valE %h cc %b want 6 8 000", M_icode, M_valE, cc); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_jxx();
    test_cmov();
    test_stack();
    test_cc_gating();
    test_bubble_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
